// File: rtl/div_control.sv
// Control FSM for an 8-bit restoring divider.
// Sequences the external datapath through load, shift, trial-subtract and restore steps.
module div_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sign,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       inbit,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_o,
  output logic [2:0] count_o,
  output logic       neg_o
);

  // start is a level request, sampled only in IDLE; done is a one-cycle result-valid pulse with no ready.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT0  = 3'd2,
    SUB     = 3'd3,
    RESTORE = 3'd4,
    SHIFT   = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       neg_q, neg_d;

  logic       load_q, load_d;
  logic       add_q, add_d;
  logic       shift_q, shift_d;
  logic       inbit_q, inbit_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD: begin
        cnt_d   = 3'd0;
        state_d = SHIFT0;
      end
      SHIFT0:  state_d = SUB;
      SUB: begin
        neg_d   = sign;
        state_d = sign ? RESTORE : SHIFT;
      end
      RESTORE: state_d = SHIFT;
      SHIFT: begin
        // Counter holds at 7 on the final shift so it never wraps mid-operation.
        if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd7) ? DONE : SUB;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so their registers track state_q and neg_q.
    load_d  = (state_d == LOAD);
    add_d   = (state_d == RESTORE);
    shift_d = (state_d == SHIFT0) || (state_d == SHIFT);
    inbit_d = (state_d == SHIFT) && !neg_d;
    sel_d   = 2'b11;
    if (state_d == LOAD) sel_d = 2'b10;
    if ((state_d == SUB) || (state_d == RESTORE)) sel_d = 2'b01;
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      neg_q   <= 1'b0;
      load_q  <= 1'b0;
      add_q   <= 1'b0;
      shift_q <= 1'b0;
      inbit_q <= 1'b0;
      sel_q   <= 2'b11;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      load_q  <= load_d;
      add_q   <= add_d;
      shift_q <= shift_d;
      inbit_q <= inbit_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign load    = load_q;
  assign add     = add_q;
  assign shift   = shift_q;
  assign inbit   = inbit_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;
  assign count_o = cnt_q;
  assign neg_o   = neg_q;

endmodule

// File: tb/tb_div_control.sv
// Bench for div_control with a behavioural restoring-divider datapath attached.
// Results and timing are compared against plain arithmetic on the operands.
module tb_div_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sign;
  logic       load, add, shift, inbit, busy, done, neg_o;
  logic [1:0] sel;
  logic [2:0] state_o, count_o;

  logic [7:0] dvnd = 8'd0;
  logic [7:0] dvsr = 8'd0;
  int         hi = 0;
  int         m  = 0;
  logic [7:0] lo = 8'd0;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [16:0] exp_q[$];   // {remainder_valid, quotient, remainder}
  logic [2:0] idle_code;

  div_control dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sign    (sign),
    .load    (load),
    .add     (add),
    .shift   (shift),
    .inbit   (inbit),
    .sel     (sel),
    .busy    (busy),
    .done    (done),
    .state_o (state_o),
    .count_o (count_o),
    .neg_o   (neg_o)
  );

  // Clock / reset-independent datapath
  always #5 clk = ~clk;

  assign sign = ((add ? hi + m : hi - m) < 0);

  always @(posedge clk) begin
    if (load) m <= int'(dvsr);
    case (sel)
      2'b10: begin
        hi <= 0;
        lo <= dvnd;
      end
      2'b01: hi <= add ? hi + m : hi - m;
      2'b11: if (shift) begin
        hi <= (hi * 2) + int'(lo[7]);
        lo <= {lo[6:0], inbit};
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [16:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q, r;
    if (b == 8'd0) return {1'b0, 8'hFF, 8'h00};
    q = a / b;
    r = a % b;
    return {1'b1, q, r};
  endfunction

  function automatic int ref_cycles(input logic [7:0] q);
    return 19 + (8 - $countones(q));
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_load"},  int'(load), 0);
    check({tag, "_add"},   int'(add), 0);
    check({tag, "_shift"}, int'(shift), 0);
    check({tag, "_inbit"}, int'(inbit), 0);
    check({tag, "_sel"},   int'(sel), 3);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_cnt"},   int'(count_o), 0);
    check({tag, "_neg"},   int'(neg_o), 0);
  endtask

  // Driver: one division from IDLE, optionally toggling start while it runs.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit noisy);
    logic [16:0] e;
    int cyc, restores, busy_cyc, exp_cyc;
    bit seen;
    exp_q.push_back(ref_div(a, b));
    @(negedge clk);
    dvnd  = a;
    dvsr  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e        = exp_q.pop_front();
    exp_cyc  = ref_cycles(e[15:8]);
    cyc      = 0;
    restores = 0;
    busy_cyc = 0;
    seen     = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      restores += int'(add);
      busy_cyc += int'(busy);
      check("load_shift_excl", int'(load & shift), 0);
      if (add) check("add_sel", int'(sel), 1);
      if (cyc == 1) check("load_first_cycle", int'(load), 1);
      if (done) seen = 1'b1;
      else if (noisy) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    check("done_seen", int'(seen), 1);
    check("done_cycle", cyc, exp_cyc);
    check("restores", restores, 8 - $countones(e[15:8]));
    check("busy_cycles", busy_cyc, exp_cyc - 1);
    check("busy_at_done", int'(busy), 0);
    check("quotient", int'(lo), int'(e[15:8]));
    if (e[16]) check("remainder", hi / 2, int'(e[7:0]));
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("done_width", int'(done), 0);
    check("idle_state", int'(state_o), int'(idle_code));
  endtask

  // Driver: start held high for n back-to-back divisions.
  task automatic run_stream(input int n);
    logic [16:0] e;
    logic [7:0] a, b;
    int gap, low_cnt;
    bit seen;
    @(negedge clk);
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(1, 255));
    dvnd  = a;
    dvsr  = b;
    exp_q.push_back(ref_div(a, b));
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      gap     = 0;
      low_cnt = 0;
      seen    = 1'b0;
      while (!seen && gap < 50) begin
        @(negedge clk);
        gap++;
        if (done) seen = 1'b1;
        else begin
          if (!busy) low_cnt++;
          if (k > 0 && gap == 1) check("stream_idle_load", int'(load), 0);
          if (k > 0 && gap == 2) check("stream_load", int'(load), 1);
        end
      end
      check("stream_done_seen", int'(seen), 1);
      e = exp_q.pop_front();
      check("stream_gap", gap, ref_cycles(e[15:8]) + ((k > 0) ? 1 : 0));
      check("stream_busy_low", low_cnt, (k > 0) ? 1 : 0);
      check("stream_busy_done", int'(busy), 0);
      check("stream_quotient", int'(lo), int'(e[15:8]));
      check("stream_remainder", hi / 2, int'(e[7:0]));
      if (k < n - 1) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(1, 255));
        dvnd = a;
        dvsr = b;
        exp_q.push_back(ref_div(a, b));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("stream_end_busy", int'(busy), 0);
    @(negedge clk);
    check("stream_end_load", int'(load), 0);
  endtask

  // Driver: async reset during iteration 4, then a clean rerun.
  task automatic run_abort;
    int cyc, shifts, done_cnt;
    @(negedge clk);
    dvnd  = 8'd200;
    dvsr  = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc    = 0;
    shifts = 0;
    while (shifts < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      shifts += int'(shift);
    end
    check("abort_reach_iter4", shifts, 4);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_idle_outputs("abort_async");
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      done_cnt += int'(done);
    end
    #2 reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      done_cnt += int'(done);
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_idle_busy", int'(busy), 0);
    run_div(8'd200, 8'd9, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    idle_code = state_o;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_busy", int'(busy), 0);

    run_div(8'd100, 8'd7, 1'b0);
    run_div(8'd255, 8'd1, 1'b0);
    run_div(8'd0,   8'd5, 1'b0);
    run_div(8'd37,  8'd0, 1'b0);
    run_abort();
    run_stream(4);
    for (int i = 0; i < 12; i++) begin
      run_div(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
